dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder at the far end of the load/store bus.
- Accepts one request per transaction, carrying a word address, a mem_access_type code (LB..SW, NONE) and store data.
- Performs a byte-lane aligned read or write on an internal 32-bit word array, then returns sign/zero-extended load data or an error flag.
- Sits behind the core's memory stage and serves as its data RAM.

Parameters:
- DEPTH, 256: number of 32-bit words in the array.
- ADDR_W, 32: byte-address width of req_addr.
- WAIT_CYCLES, 0: extra wait states between request accept and response (0..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_access  in  4  mem_access_type code: LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7 NONE=8.
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores, NONE and errors.
- resp_err  out  1  access fault.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge.
  - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, capture addr/access/wdata. Go to WAIT if WAIT_CYCLES>0 (counter=WAIT_CYCLES-1), else go to RESP.
  - WAIT: req_ready=0. Decrement counter. When counter==0, go to RESP.
  - The array access and the response registers update on the clock edge that enters RESP.
  - RESP: resp_valid=1, with resp_rdata/resp_err stable. Outputs hold until resp_ready. On resp_valid&&resp_ready, go to IDLE and clear resp_valid.
- Latency: request accepted at edge T; resp_valid is high from edge T+1+WAIT_CYCLES.
- Throughput: a new request can be accepted no earlier than the edge after the response handshake, so at most one transaction every 2+WAIT_CYCLES cycles.
- Addressing:
  - Word index = addr[ADDR_W-1:2]; byte offset = addr[1:0]; little-endian lanes.
- Loads:
  - LB/LBU select byte at offset; LB sign-extends, LBU zero-extends.
  - LH/LHU select halfword at offset[1]; LH sign-extends, LHU zero-extends.
  - LW returns the full word.
- Stores:
  - SB writes the single lane at offset; byte enable = 1<<offset.
  - SH writes two lanes; byte enable = 0011 or 1100 by offset[1].
  - SW writes all four lanes.
  - Unselected lanes are preserved.
- Errors (resp_err=1, no write, rdata=0):
  - word index >= DEPTH;
  - misaligned access (see Optional Feature);
  - req_access codes 9..15.
- NONE: completes normally with err=0, rdata=0, and no array effect.
- Reset mid-operation: returns to IDLE and drops any pending response.
  - A store not yet committed (still in WAIT) is discarded.
  - A store already committed persists.
- req_valid in WAIT or RESP is ignored, since req_ready=0. The requester must hold the request until req_ready is seen.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: the following are faults, with resp_err=1, no write, rdata=0:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0.
- Undefined: misaligned accesses are force-aligned and never fault.
  - Halfword ops ignore addr[0].
  - Word ops ignore addr[1:0].

Test Plan:
- WAIT_CYCLES=0: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata=0xDEADBEEF, err=0. resp_valid rises exactly 1 cycle after each accept.
- After the above: SB addr 0x11 data 0x7F, then LB 0x11 -> 0x0000007F. LW 0x10 -> 0xDEAD7FEF. LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE.
- LH 0x12 -> 0xFFFFDEAD. LHU 0x12 -> 0x0000DEAD. SH 0x10 data 0x1234, then LW 0x10 -> 0xDEAD1234.
- WAIT_CYCLES=3 with resp_ready held low for 4 cycles -> resp_valid at accept+4, and data and valid stay stable until resp_ready. req_ready stays 0 throughout.
- LW addr DEPTH*4 -> err=1, rdata=0. Code 12 -> err=1. NONE -> err=0, rdata=0. With DMEM_MISALIGN_ERR_EN: SW 0x21 -> err=1, and a subsequent LW 0x20 is unchanged.
- WAIT_CYCLES=3: SW 0x30 data 0x55, then rst_n low during WAIT -> resp_valid=0 and req_ready=1 after reset, and a subsequent LW 0x30 does not return 0x55 (prior contents preserved).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per transaction on a DEPTH x 32-bit byte-lane array.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after the accept edge; one transaction in flight.
// Backpressure: req_ready low from accept until the response handshake; response held until resp_ready.
// Optional: define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses instead of force-aligning them.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_access,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] A_LB   = 4'd0;
    localparam logic [3:0] A_LH   = 4'd1;
    localparam logic [3:0] A_LW   = 4'd2;
    localparam logic [3:0] A_LBU  = 4'd3;
    localparam logic [3:0] A_LHU  = 4'd4;
    localparam logic [3:0] A_SB   = 4'd5;
    localparam logic [3:0] A_SH   = 4'd6;
    localparam logic [3:0] A_SW   = 4'd7;
    localparam logic [3:0] A_NONE = 4'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [3:0]        cap_access;
    logic [31:0]       cap_wdata;
    logic [31:0]       mem [DEPTH];

    // With zero wait states the access happens on the accept edge, so decode straight from the request.
    logic [ADDR_W-1:0] acc_addr;
    logic [3:0]        acc_access;
    logic [31:0]       acc_wdata;
    assign acc_addr   = (state == ST_IDLE) ? req_addr   : cap_addr;
    assign acc_access = (state == ST_IDLE) ? req_access : cap_access;
    assign acc_wdata  = (state == ST_IDLE) ? req_wdata  : cap_wdata;

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        off;
    logic [31:0]       rd_word, sh_b, sh_h;
    assign word_idx = acc_addr[ADDR_W-1:2];
    assign off      = acc_addr[1:0];
    assign rd_word  = mem[word_idx[IDX_W-1:0]];
    assign sh_b     = rd_word >> {off, 3'b000};
    assign sh_h     = rd_word >> {off[1], 4'b0000};

    logic [31:0] ld_data, st_data;
    logic [3:0]  be;
    logic        is_store, bad_code, misalign, range_err, err, commit;

    always_comb begin
        ld_data  = 32'd0;
        st_data  = 32'd0;
        be       = 4'b0000;
        is_store = 1'b0;
        bad_code = 1'b0;
        misalign = 1'b0;
        case (acc_access)
            A_LB:    ld_data = {{24{sh_b[7]}}, sh_b[7:0]};
            A_LBU:   ld_data = {24'd0, sh_b[7:0]};
            A_LH:    ld_data = {{16{sh_h[15]}}, sh_h[15:0]};
            A_LHU:   ld_data = {16'd0, sh_h[15:0]};
            A_LW:    ld_data = rd_word;
            A_SB: begin
                is_store = 1'b1;
                be       = 4'b0001 << off;
                st_data  = {4{acc_wdata[7:0]}};
            end
            A_SH: begin
                is_store = 1'b1;
                be       = off[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{acc_wdata[15:0]}};
            end
            A_SW: begin
                is_store = 1'b1;
                be       = 4'b1111;
                st_data  = acc_wdata;
            end
            A_NONE:  ;
            default: bad_code = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_ERR_EN
        if (((acc_access == A_LH) || (acc_access == A_LHU) || (acc_access == A_SH)) && off[0])
            misalign = 1'b1;
        if (((acc_access == A_LW) || (acc_access == A_SW)) && (off != 2'b00))
            misalign = 1'b1;
`endif
    end

    assign range_err = (word_idx >= (ADDR_W-2)'(DEPTH));
    assign err       = range_err | bad_code | misalign;
    assign commit    = ((state == ST_IDLE) && req_valid && req_ready && (WAIT_CYCLES == 0)) ||
                       ((state == ST_WAIT) && (wait_cnt == 4'd0));

    // Array is not reset; a store commits only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (rst_n && commit && is_store && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[word_idx[IDX_W-1:0]][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            wait_cnt   <= 4'd0;
        end else begin
            if (commit) begin
                state      <= ST_RESP;
                req_ready  <= 1'b0;
                resp_valid <= 1'b1;
                resp_rdata <= err ? 32'd0 : ld_data;
                resp_err   <= err;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        cap_addr   <= req_addr;
                        cap_access <= req_access;
                        cap_wdata  <= req_wdata;
                        if (WAIT_CYCLES > 0) begin
                            state     <= ST_WAIT;
                            req_ready <= 1'b0;
                            wait_cnt  <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0)
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut index 0 runs with no wait states, index 1 with three.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LBU = 4'd3, LHU = 4'd4;
    localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7, NONE = 4'd8;

    logic        clk = 1'b0;
    logic [1:0]  rst_n = 2'b00;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_addr [2];
    logic [3:0]  req_access [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] resp_rdata [2];
    logic [1:0]  resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_access(req_access[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_access(req_access[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full transaction: accept, wait for the response, hold it for `hold` cycles, then handshake.
    task automatic txn(input int d, input string tag, input logic [31:0] addr, input logic [3:0] acc,
                       input logic [31:0] wd, input int hold, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        check({tag, ":req_ready_idle"}, 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_addr[d]   = addr;
        req_access[d] = acc;
        req_wdata[d]  = wd;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        n = 1;
        while (!resp_valid[d] && n < 20) begin
            check({tag, ":req_ready_wait"}, 32'(req_ready[d]), 32'd0);
            @(posedge clk); #1;
            n++;
        end
        check({tag, ":latency"}, 32'(n), (d == 0) ? 32'd1 : 32'd4);
        check({tag, ":rdata"}, resp_rdata[d], exp_rd);
        check({tag, ":err"}, 32'(resp_err[d]), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ":hold_valid"}, 32'(resp_valid[d]), 32'd1);
            check({tag, ":hold_rdata"}, resp_rdata[d], exp_rd);
            check({tag, ":hold_req_ready"}, 32'(req_ready[d]), 32'd0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        resp_ready[d] = 1'b0;
        check({tag, ":valid_drop"}, 32'(resp_valid[d]), 32'd0);
        check({tag, ":req_ready_back"}, 32'(req_ready[d]), 32'd1);
    endtask

    task automatic pulse_reset(input int d);
        rst_n[d] = 1'b0;
        @(posedge clk); #1;
        rst_n[d] = 1'b1;
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = 32'd0; req_access[d] = NONE; req_wdata[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 2'b11;
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", 32'(req_ready[d]), 32'd1);
            check("reset_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("reset_rdata", resp_rdata[d], 32'd0);
            check("reset_err", 32'(resp_err[d]), 32'd0);
        end

        // Basic lanes and extension, zero wait states
        txn(0, "sw10",   32'h10, SW,  32'hDEADBEEF, 0, 32'h0,        1'b0);
        txn(0, "lw10",   32'h10, LW,  32'h0,        0, 32'hDEADBEEF, 1'b0);
        txn(0, "sb11",   32'h11, SB,  32'hFFFFFF7F, 0, 32'h0,        1'b0);
        txn(0, "lb11",   32'h11, LB,  32'h0,        0, 32'h0000007F, 1'b0);
        txn(0, "lw10b",  32'h10, LW,  32'h0,        0, 32'hDEAD7FEF, 1'b0);
        txn(0, "lb13",   32'h13, LB,  32'h0,        0, 32'hFFFFFFDE, 1'b0);
        txn(0, "lbu13",  32'h13, LBU, 32'h0,        0, 32'h000000DE, 1'b0);
        txn(0, "lh12",   32'h12, LH,  32'h0,        0, 32'hFFFFDEAD, 1'b0);
        txn(0, "lhu12",  32'h12, LHU, 32'h0,        0, 32'h0000DEAD, 1'b0);
        txn(0, "sh10",   32'h10, SH,  32'hABCD1234, 0, 32'h0,        1'b0);
        txn(0, "lw10c",  32'h10, LW,  32'h0,        0, 32'hDEAD1234, 1'b0);
        txn(0, "lh10",   32'h10, LH,  32'h0,        0, 32'h00001234, 1'b0);
        txn(0, "sb10",   32'h10, SB,  32'h00000080, 0, 32'h0,        1'b0);
        txn(0, "lb10",   32'h10, LB,  32'h0,        0, 32'hFFFFFF80, 1'b0);
        txn(0, "lw10d",  32'h10, LW,  32'h0,        0, 32'hDEAD1280, 1'b0);

        // Range edges, illegal code, NONE
        txn(0, "sw_last", 32'h3FC, SW, 32'h01020304, 0, 32'h0,        1'b0);
        txn(0, "lw_last", 32'h3FC, LW, 32'h0,        0, 32'h01020304, 1'b0);
        txn(0, "lw_oob",  DEPTH*4, LW, 32'h0,        0, 32'h0,        1'b1);
        txn(0, "sw_oob",  DEPTH*4, SW, 32'h11111111, 0, 32'h0,        1'b1);
        txn(0, "code12",  32'h10,  4'd12, 32'h0,     0, 32'h0,        1'b1);
        txn(0, "none",    32'h10,  NONE, 32'hFFFFFFFF, 0, 32'h0,      1'b0);
        txn(0, "lw10e",   32'h10,  LW, 32'h0,        0, 32'hDEAD1280, 1'b0);

        // Misaligned word store
        txn(0, "sw20",    32'h20, SW, 32'hCAFEF00D, 0, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_ERR_EN
        txn(0, "sw21",    32'h21, SW, 32'h11223344, 0, 32'h0, 1'b1);
        txn(0, "lw20",    32'h20, LW, 32'h0,        0, 32'hCAFEF00D, 1'b0);
        txn(0, "lh13",    32'h13, LH, 32'h0,        0, 32'h0, 1'b1);
`else
        txn(0, "sw21",    32'h21, SW, 32'h11223344, 0, 32'h0, 1'b0);
        txn(0, "lw20",    32'h20, LW, 32'h0,        0, 32'h11223344, 1'b0);
        txn(0, "lh13",    32'h13, LH, 32'h0,        0, 32'hFFFFDEAD, 1'b0);
`endif

        // Three wait states with a stalled consumer
        txn(1, "w_sw40", 32'h40, SW, 32'h89ABCDEF, 0, 32'h0,        1'b0);
        txn(1, "w_lw40", 32'h40, LW, 32'h0,        4, 32'h89ABCDEF, 1'b0);
        txn(1, "w_lhu42", 32'h42, LHU, 32'h0,      1, 32'h000089AB, 1'b0);

        // Reset during WAIT discards the pending store
        txn(1, "w_sw30", 32'h30, SW, 32'hA5A5A5A5, 0, 32'h0, 1'b0);
        req_valid[1] = 1'b1; req_addr[1] = 32'h30; req_access[1] = SW; req_wdata[1] = 32'h55;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        pulse_reset(1);
        check("rst_wait_valid", 32'(resp_valid[1]), 32'd0);
        check("rst_wait_req_ready", 32'(req_ready[1]), 32'd1);
        txn(1, "w_lw30", 32'h30, LW, 32'h0, 0, 32'hA5A5A5A5, 1'b0);

        // Reset during RESP keeps the committed store but drops the response
        req_valid[1] = 1'b1; req_addr[1] = 32'h34; req_access[1] = SW; req_wdata[1] = 32'h77;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        n = 0;
        while (!resp_valid[1] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_resp_reached", 32'(resp_valid[1]), 32'd1);
        pulse_reset(1);
        check("rst_resp_valid", 32'(resp_valid[1]), 32'd0);
        check("rst_resp_req_ready", 32'(req_ready[1]), 32'd1);
        txn(1, "w_lw34", 32'h34, LW, 32'h0, 0, 32'h00000077, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
